// File: rtl/sync_fifo_flags_pkg.sv
// Shared definitions for the sync_fifo_flags FIFO family.
//   FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter.
//   fifo_clog2()         : constant-foldable ceil(log2) for address sizing.
//   SFF_THRESH_LEGAL     : elaboration-time legality test for the
//                          almost-full / almost-empty thresholds.
`ifndef SYNC_FIFO_FLAGS_PKG_SV
`define SYNC_FIFO_FLAGS_PKG_SV

// True when 1 <= af <= depth and 0 <= ae <= depth-1.
`define SFF_THRESH_LEGAL(af, ae, depth) \
  (((af) >= 1) && ((af) <= (depth)) && ((ae) >= 0) && ((ae) <= ((depth) - 1)))

package sync_fifo_flags_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int fifo_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/sync_fifo_flags_mem_dp.sv
// fifo_mem_dp: DEPTH x WIDTH storage array for the FIFO.
// Synchronous write, asynchronous (combinational) read, no reset on storage.
// Ports:
//   i_clk   - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data, combinational from i_raddr
module fifo_mem_dp
  import sync_fifo_flags_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = fifo_clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with fill count, programmable
// almost-full/almost-empty flags, overflow/underflow pulses and a
// selectable standard or first-word-fall-through read port.
// Ports:
//   i_clk, i_rst       - clock (rising edge), asynchronous active-high reset
//   i_wr_en, i_din     - write request and data
//   i_rd_en            - read request / pop
//   o_dout             - read data (registered in standard mode, head word in FWFT)
//   o_full, o_empty    - occupancy == DEPTH / == 0
//   o_almost_full      - count >= AF_THRESH
//   o_almost_empty     - count <= AE_THRESH
//   o_count            - occupancy 0..DEPTH
//   o_overflow         - pulse: previous cycle's write was rejected
//   o_underflow        - pulse: previous cycle's read was rejected
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FIFO_STD
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [WIDTH-1:0]  i_din,
  input  logic              i_rd_en,
  output logic [WIDTH-1:0]  o_dout,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] PtrOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FullCnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AfCnt   = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AeCnt   = AE_THRESH[ADDR_W:0];

  // Elaboration-time parameter checks.
  if (!`SFF_THRESH_LEGAL(AF_THRESH, AE_THRESH, DEPTH)) begin : g_bad_thresh
    $fatal(1, "sync_fifo_flags: AF_THRESH/AE_THRESH out of range for DEPTH");
  end
  if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
    $fatal(1, "sync_fifo_flags: FWFT must be FIFO_STD or FIFO_FWFT");
  end

  // MSB of each pointer is the wrap flag; low bits address memory.
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic [ADDR_W:0]  r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic [ADDR_W:0]  w_wr_ptr_d;
  logic [ADDR_W:0]  w_rd_ptr_d;
  logic [ADDR_W:0]  w_count_d;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_rdata;

  assign w_full  = (r_count == FullCnt);
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is allowed when a read frees a slot in the same
  // cycle. No bypass when empty: the read is rejected even if a write lands.
  assign w_rd_ok = i_rd_en & ~w_empty;
  assign w_wr_ok = i_wr_en & (~w_full | w_rd_ok);

  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    if (w_wr_ok) begin
      w_wr_ptr_d = r_wr_ptr + PtrOne;
    end
    if (w_rd_ok) begin
      w_rd_ptr_d = r_rd_ptr + PtrOne;
    end
    // Modulo 2**(ADDR_W+1) difference keeps count exact across wraps.
    w_count_d = w_wr_ptr_d - w_rd_ptr_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_count     <= w_count_d;
      r_overflow  <= i_wr_en & ~w_wr_ok;
      r_underflow <= i_rd_en & ~w_rd_ok;
    end
  end

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (i_din),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Head word shown directly; meaningless while empty.
    assign o_dout = w_rdata;
  end else begin : g_std
    logic [WIDTH-1:0] r_dout;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_dout <= '0;
      end else if (w_rd_ok) begin
        r_dout <= w_rdata;
      end
    end
    assign o_dout = r_dout;
  end

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= AfCnt);
  assign o_almost_empty = (r_count <= AeCnt);
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags. Two instances (standard and FWFT)
// share the same stimulus and are compared each cycle against a queue model.
module tb_sync_fifo_flags;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AF     = 12;
  localparam int AE     = 2;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] din;

  logic [WIDTH-1:0] s_dout, f_dout;
  logic             s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic             f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [ADDR_W:0]  s_count, f_count;

  int n_checks;
  int n_errors;

  // Reference model state.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_std;
  bit               exp_ovf;
  bit               exp_udf;

  sync_fifo_flags #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .AF_THRESH (AF),
    .AE_THRESH (AE),
    .FWFT      (0)
  ) u_std (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wr_en        (wr_en),
    .i_din          (din),
    .i_rd_en        (rd_en),
    .o_dout         (s_dout),
    .o_full         (s_full),
    .o_empty        (s_empty),
    .o_almost_full  (s_af),
    .o_almost_empty (s_ae),
    .o_count        (s_count),
    .o_overflow     (s_ovf),
    .o_underflow    (s_udf)
  );

  sync_fifo_flags #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .AF_THRESH (AF),
    .AE_THRESH (AE),
    .FWFT      (1)
  ) u_fwft (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wr_en        (wr_en),
    .i_din          (din),
    .i_rd_en        (rd_en),
    .o_dout         (f_dout),
    .o_full         (f_full),
    .o_empty        (f_empty),
    .o_almost_full  (f_af),
    .o_almost_empty (f_ae),
    .o_count        (f_count),
    .o_overflow     (f_ovf),
    .o_underflow    (f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare both instances against the model's current occupancy.
  task automatic check_all();
    int n;
    n = q.size();
    check("std.count", 32'(s_count), n);
    check("std.empty", 32'(s_empty), 32'(n == 0));
    check("std.full", 32'(s_full), 32'(n == DEPTH));
    check("std.afull", 32'(s_af), 32'(n >= AF));
    check("std.aempty", 32'(s_ae), 32'(n <= AE));
    check("std.ovf", 32'(s_ovf), 32'(exp_ovf));
    check("std.udf", 32'(s_udf), 32'(exp_udf));
    check("std.dout", 32'(s_dout), 32'(exp_std));
    check("fwft.count", 32'(f_count), n);
    check("fwft.empty", 32'(f_empty), 32'(n == 0));
    check("fwft.full", 32'(f_full), 32'(n == DEPTH));
    check("fwft.afull", 32'(f_af), 32'(n >= AF));
    check("fwft.aempty", 32'(f_ae), 32'(n <= AE));
    check("fwft.ovf", 32'(f_ovf), 32'(exp_ovf));
    check("fwft.udf", 32'(f_udf), 32'(exp_udf));
    if (n > 0) begin
      check("fwft.dout", 32'(f_dout), 32'(q[0]));
    end
  endtask

  // One clock: drive inputs, advance the model, check at the falling edge.
  task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd);
    bit rok;
    bit wok;
    wr_en = wr;
    din   = d;
    rd_en = rd;
    rok   = rd && (q.size() > 0);
    wok   = wr && ((q.size() < DEPTH) || rok);
    if (rok) exp_std = q.pop_front();
    if (wok) q.push_back(d);
    exp_ovf = wr && !wok;
    exp_udf = rd && !rok;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [WIDTH-1:0] pat;
    int               pw;
    int               pr;
    n_checks = 0;
    n_errors = 0;
    exp_std  = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = '0;
    rst      = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    step(0, 8'h00, 0);

    // Fill 0x01..0x10, then one rejected write.
    for (int i = 1; i <= DEPTH; i++) step(1, 8'(i), 0);
    step(1, 8'h99, 0);
    step(0, 8'h00, 0);

    // Drain in order, then one rejected read; dout must hold 0x10.
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    check("drain.last", 32'(s_dout), 32'h10);

    // Full with simultaneous read/write.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h20 + i), 0);
    step(1, 8'hAA, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);
    check("full_rw.last", 32'(s_dout), 32'hAA);

    // Empty with simultaneous read/write: read rejected, no bypass.
    step(1, 8'h55, 1);
    check("empty_rw.fwft", 32'(f_dout), 32'h55);
    step(0, 8'h00, 1);

    // Wrap-around at half occupancy.
    pat = 8'h80;
    for (int i = 0; i < DEPTH / 2; i++) begin
      step(1, pat, 0);
      pat = pat + 8'd1;
    end
    for (int i = 0; i < 40; i++) begin
      step(1, pat, 1);
      pat = pat + 8'd1;
    end
    for (int i = 0; i < DEPTH / 2; i++) step(0, 8'h00, 1);

    // Asynchronous reset in the middle of the low phase at count 7.
    for (int i = 0; i < 7; i++) step(1, 8'(8'h40 + i), 0);
    #2 rst = 1'b1;
    q.delete();
    exp_std = '0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    #1 check_all();
    #1 rst = 1'b0;
    step(1, 8'h3C, 0);
    step(0, 8'h00, 1);
    check("post_rst.std", 32'(s_dout), 32'h3C);
    step(0, 8'h00, 0);

    // Randomized traffic with shifting write/read bias to visit full and empty.
    for (int blk = 0; blk < 8; blk++) begin
      pw = (blk % 2 == 0) ? 75 : 25;
      pr = (blk % 2 == 0) ? 25 : 75;
      for (int i = 0; i < 50; i++) begin
        step(($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < pr));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Adds configurable width and depth, a selectable read mode (standard or first-word-fall-through), a fill count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses.
- Sits between a producer and a consumer in the same clock domain as a general-purpose elastic buffer.

Parameters:
- WIDTH, 8, data word width in bits.
- ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W entries.
- AF_THRESH, 12, almost_full asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through (show-ahead).

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- wr_en, input, 1, write request.
- din, input, WIDTH, write data.
- rd_en, input, 1, read request / pop.
- dout, output, WIDTH, read data.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= AF_THRESH.
- almost_empty, output, 1, count <= AE_THRESH.
- count, output, ADDR_W+1, current occupancy, 0..DEPTH.
- overflow, output, 1, one-cycle pulse: previous cycle's write was rejected.
- underflow, output, 1, one-cycle pulse: previous cycle's read was rejected.

Behaviour:
- Reset: one clock, clk. rst is asynchronous and active-high; assertion clears state immediately, independent of clk.
  - Reset values: pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, dout = 0.
  - Memory contents are not reset.
  - Reset mid-operation flushes all contents; the first write after deassertion goes to entry 0.
- Pointers: rd_ptr and wr_ptr are ADDR_W+1 bits. The low ADDR_W bits address memory; the MSB is the wrap flag.
- count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1), registered. Flags are decoded combinationally from the registered count and pointers.
- Read accepted: rd_ok = rd_en & !empty.
- Write accepted: wr_ok = wr_en & (!full | rd_ok).
  - When full with rd_en and wr_en both high, a read and a write occur in the same cycle; count is unchanged.
- Empty with rd_en and wr_en both high:
  - The write is accepted; the read is rejected.
  - There is no bypass of din to dout; underflow pulses.
- count update per clock: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- overflow <= wr_en & !wr_ok; underflow <= rd_en & !rd_ok. Both are single-cycle registered pulses.
- Rejected operations never move a pointer or modify memory.
- FWFT = 0 (standard read):
  - On rd_ok, dout is loaded with mem[rd_ptr] at that edge, so data is valid the cycle after rd_en.
  - dout holds its value otherwise.
- FWFT = 1 (show-ahead read):
  - dout = mem[rd_ptr] combinationally; it is valid whenever empty = 0.
  - rd_en acknowledges and pops the head word.
  - While empty, dout is don't-care.
- Write-to-read latency: empty deasserts in the cycle after the first write edge.
  - FWFT = 1: the word is on dout in that same cycle.
  - FWFT = 0: the word is on dout one cycle after the rd_en that pops it.
- Wrap-around: the low pointer bits roll from DEPTH-1 to 0 and the MSB toggles. full and empty remain correct across any number of wraps.
- Thresholds are static parameters. Out-of-range values are an elaboration error (a generate-time check).

Decomposition:
- Shared package/include holds:
  - FIFO mode constants: FIFO_STD = 0, FIFO_FWFT = 1.
  - A clog2 helper function.
  - The threshold legality check macro.
- Natural sub-module: fifo_mem_dp.
  - DEPTH x WIDTH storage with synchronous write and asynchronous read.
  - No reset on storage.
- The top level holds pointers, count, flags, error pulses and the dout register.

Test Plan:
- Fill (WIDTH = 8, ADDR_W = 4): write 16 words 0x01..0x10 with rd_en = 0.
  - count 0→16.
  - almost_full rises on the cycle count reaches 12.
  - full = 1 after the 16th write.
  - A 17th write gives overflow = 1 for one cycle, count stays 16, and memory is unchanged.
- Drain (FWFT = 0): read until empty.
  - dout = 0x01..0x10 in order, each one cycle after its rd_en.
  - almost_empty rises at count = 2.
  - An extra read gives underflow = 1, and dout holds 0x10.
- Full with simultaneous rd_en and wr_en (din = 0xAA): count stays 16 and full stays 1. After draining, 0xAA is the last word out.
- Empty with simultaneous rd_en and wr_en (din = 0x55): underflow = 1, count = 1, empty = 0 next cycle. With FWFT = 1, dout = 0x55 that cycle.
- Wrap-around: 40 interleaved write/read pairs at half occupancy with an incrementing pattern; zero data mismatches and pointer MSB toggles observed.
- Asynchronous reset asserted mid-clock at count = 7:
  - Flags take their reset values immediately, without a clock edge: empty = 1, count = 0, full = 0.
  - After release, a write of 0x3C then a read returns 0x3C.
